// File: rtl/typedefs.sv
// Shared CPU types: opcode and sequencer phase encodings plus datapath sizes.
package typedefs;

    localparam int BIT_SIZE = 8;
    localparam int BC_SIZE  = 3;

    typedef enum logic [BC_SIZE-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [BC_SIZE-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: (phase, opcode, zero, halted) -> control strobes.
module ctrl_decode
    import typedefs::*;
(
    input  state_t  phase_i,
    input  opcode_t opcode_i,
    input  logic    zero_i,
    input  logic    halted_i,
    output logic    mem_rd_o,
    output logic    mem_wr_o,
    output logic    load_ir_o,
    output logic    load_ac_o,
    output logic    load_pc_o,
    output logic    inc_pc_o,
    output logic    halt_o
);

    logic aluop;

    // Decode strobes per phase; a halted CPU drives no strobes at all.
    always_comb begin
        mem_rd_o  = 1'b0;
        mem_wr_o  = 1'b0;
        load_ir_o = 1'b0;
        load_ac_o = 1'b0;
        load_pc_o = 1'b0;
        inc_pc_o  = 1'b0;
        aluop     = is_aluop(opcode_i);
        halt_o    = halted_i || ((phase_i == OP_ADDR) && (opcode_i == HLT));
        if (!halted_i) begin
            unique case (phase_i)
                INST_ADDR: ;
                INST_FETCH: mem_rd_o = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd_o  = 1'b1;
                    load_ir_o = 1'b1;
                end
                OP_ADDR: inc_pc_o = 1'b1;
                OP_FETCH: mem_rd_o = aluop;
                ALU_OP: begin
                    mem_rd_o  = aluop;
                    load_ac_o = aluop;
                    inc_pc_o  = (opcode_i == SKZ) && zero_i;
                    load_pc_o = (opcode_i == JMP);
                end
                STORE: begin
                    mem_rd_o  = aluop;
                    load_ac_o = aluop;
                    inc_pc_o  = (opcode_i == JMP);
                    load_pc_o = (opcode_i == JMP);
                    mem_wr_o  = (opcode_i == STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer with halt latch and strobe decoder.
// Optional macro CTRL_STEP_EN adds the `step` port: each instruction waits in
// INST_ADDR until a step pulse is sampled there.
module cpu_controller
    import typedefs::*;
(
    input  logic    clk,
    input  logic    rst,
    input  opcode_t opcode,
    input  logic    zero,
`ifdef CTRL_STEP_EN
    input  logic    step,
`endif
    output logic    mem_rd,
    output logic    mem_wr,
    output logic    load_ir,
    output logic    load_ac,
    output logic    load_pc,
    output logic    inc_pc,
    output logic    halt,
    output state_t  phase
);

    state_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   advance;

    // Next phase: hold while halted (parked in OP_FETCH), optionally gate in INST_ADDR.
    always_comb begin
`ifdef CTRL_STEP_EN
        advance = (phase_q != INST_ADDR) || step;
`else
        advance = 1'b1;
`endif
        halted_d = halted_q || ((phase_q == OP_ADDR) && (opcode == HLT));
        phase_d  = phase_q;
        if (!halted_q && advance) begin
            unique case (phase_q)
                INST_ADDR:  phase_d = INST_FETCH;
                INST_FETCH: phase_d = INST_LOAD;
                INST_LOAD:  phase_d = IDLE;
                IDLE:       phase_d = OP_ADDR;
                OP_ADDR:    phase_d = OP_FETCH;
                OP_FETCH:   phase_d = ALU_OP;
                ALU_OP:     phase_d = STORE;
                STORE:      phase_d = INST_ADDR;
                default:    phase_d = INST_ADDR;
            endcase
        end
    end

    // Phase and halt registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign phase = phase_q;

    ctrl_decode u_decode (
        .phase_i   (phase_q),
        .opcode_i  (opcode),
        .zero_i    (zero),
        .halted_i  (halted_q),
        .mem_rd_o  (mem_rd),
        .mem_wr_o  (mem_wr),
        .load_ir_o (load_ir),
        .load_ac_o (load_ac),
        .load_pc_o (load_pc),
        .inc_pc_o  (inc_pc),
        .halt_o    (halt)
    );

endmodule
